// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// The operand signedness helpers are derived from funct3.
package muldiv_pkg;

  localparam int SIZE  = 32;
  localparam int CNT_W = $clog2(SIZE) + 1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_signed_a(op_e op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic op_signed_b(op_e op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [SIZE-1:0] neg_if(logic neg, logic [SIZE-1:0] v);
    return neg ? (~v + {{(SIZE-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
();

  logic            start_i;
  logic            flush_i;
  logic [2:0]      op_i;
  logic [SIZE-1:0] SrcAE;
  logic [SIZE-1:0] SrcBE;
  logic            stall_o;
  logic            done_o;
  logic [SIZE-1:0] result_o;

  modport master (
    output start_i, flush_i, op_i, SrcAE, SrcBE,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, flush_i, op_i, SrcAE, SrcBE,
    output stall_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_unit.sv
// Fixed-latency iterative RV32M multiply/divide: magnitudes are iterated for
// SIZE cycles, then the sign fix and special cases are applied on the way out.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [2*SIZE-1:0] acc_q, acc_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic [SIZE-1:0]   a_orig_q, a_orig_d;
  logic [SIZE-1:0]   res_q, res_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              div0_q, div0_d, ovf_q, ovf_d;
  logic              done_q, done_d;

  op_e               op_in_s;
  logic              sa_in_s, sb_in_s, accept_s, last_s;
  logic [SIZE-1:0]   a_abs_s, b_abs_s;
  logic [SIZE:0]     mul_sum_s, rem_sh_s, div_diff_s;
  logic [2*SIZE-1:0] step_s, prod_s;
  logic [SIZE-1:0]   quo_s, rem_s, final_s;

  assign op_in_s  = op_e'(bus.op_i);
  assign sa_in_s  = op_signed_a(op_in_s) & bus.SrcAE[SIZE-1];
  assign sb_in_s  = op_signed_b(op_in_s) & bus.SrcBE[SIZE-1];
  assign a_abs_s  = neg_if(sa_in_s, bus.SrcAE);
  assign b_abs_s  = neg_if(sb_in_s, bus.SrcBE);
  assign accept_s = (state_q == IDLE) & bus.start_i & ~bus.flush_i;
  assign last_s   = (cnt_q == CNT_W'(SIZE - 1));

  assign bus.stall_o  = accept_s | (state_q == BUSY);
  assign bus.done_o   = done_q;
  assign bus.result_o = res_q;

  // One iteration: shift-add (low half holds the remaining multiplier bits) or
  // restoring subtract (high half is the partial remainder, low half the dividend/quotient).
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, b_q} : {(SIZE+1){1'b0}});
    rem_sh_s   = acc_q[2*SIZE-1:SIZE-1];
    div_diff_s = rem_sh_s - {1'b0, b_q};
    if (op_q[2]) begin
      if (div_diff_s[SIZE]) begin
        step_s = {rem_sh_s[SIZE-1:0], acc_q[SIZE-2:0], 1'b0};
      end else begin
        step_s = {div_diff_s[SIZE-1:0], acc_q[SIZE-2:0], 1'b1};
      end
    end else begin
      step_s = {mul_sum_s, acc_q[SIZE-1:1]};
    end
  end

  // Sign fix and special-case override on the final iteration's result.
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? (~step_s + {{(2*SIZE-1){1'b0}}, 1'b1}) : step_s;
    quo_s  = neg_if(sa_q ^ sb_q, step_s[SIZE-1:0]);
    rem_s  = neg_if(sa_q, step_s[2*SIZE-1:SIZE]);
    case (op_q)
      OP_MUL: final_s = prod_s[SIZE-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_s[2*SIZE-1:SIZE];
      OP_DIV, OP_DIVU: begin
        if (div0_q) begin
          final_s = {SIZE{1'b1}};
        end else if (ovf_q) begin
          final_s = {1'b1, {(SIZE-1){1'b0}}};
        end else begin
          final_s = quo_s;
        end
      end
      OP_REM, OP_REMU: begin
        if (div0_q) begin
          final_s = a_orig_q;
        end else if (ovf_q) begin
          final_s = {SIZE{1'b0}};
        end else begin
          final_s = rem_s;
        end
      end
      default: final_s = {SIZE{1'b0}};
    endcase
  end

  // Next-state, operand capture and output staging.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    b_d      = b_q;
    a_orig_d = a_orig_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    res_d    = {SIZE{1'b0}};
    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_d  = BUSY;
            cnt_d    = {CNT_W{1'b0}};
            op_d     = op_in_s;
            acc_d    = {{SIZE{1'b0}}, a_abs_s};
            b_d      = b_abs_s;
            a_orig_d = bus.SrcAE;
            sa_d     = sa_in_s;
            sb_d     = sb_in_s;
            div0_d   = op_in_s[2] & (bus.SrcBE == {SIZE{1'b0}});
            ovf_d    = ((op_in_s == OP_DIV) | (op_in_s == OP_REM))
                     & (bus.SrcAE == {1'b1, {(SIZE-1){1'b0}}})
                     & (bus.SrcBE == {SIZE{1'b1}});
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          acc_d = step_s;
          if (last_s) begin
            state_d = DONE;
            cnt_d   = {CNT_W{1'b0}};
            done_d  = 1'b1;
            res_d   = final_s;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      op_q     <= OP_MUL;
      acc_q    <= {(2*SIZE){1'b0}};
      b_q      <= {SIZE{1'b0}};
      a_orig_q <= {SIZE{1'b0}};
      res_q    <= {SIZE{1'b0}};
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      a_orig_q <= a_orig_d;
      res_q    <= res_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a cycle-level arithmetic model is compared on
// every falling edge, and each operation is also pinned to a hand-computed value.
module tb_muldiv_unit;

  localparam int SZ = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int          m_age = -1;
  logic [31:0] m_exp = 32'h0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = 64'h0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      3'd7: return (b == 32'h0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Model: m_age counts cycles since acceptance (-1 when idle); result appears at age SZ+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= -1;
      m_exp <= 32'h0;
    end else if (bus.flush_i) begin
      m_age <= -1;
    end else if (m_age == -1) begin
      if (bus.start_i) begin
        m_age <= 1;
        m_exp <= ref_result(bus.op_i, bus.SrcAE, bus.SrcBE);
      end
    end else if (m_age == SZ + 1) begin
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_stall, exp_done;
      exp_stall = (m_age == -1) ? (bus.start_i && !bus.flush_i) : (m_age <= SZ);
      exp_done  = (m_age == SZ + 1);
      check("model_stall", {31'h0, bus.stall_o}, {31'h0, exp_stall});
      check("model_done", {31'h0, bus.done_o}, {31'h0, exp_done});
      check("model_result", bus.result_o, exp_done ? m_exp : 32'h0);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int   cyc;
    logic seen;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      bus.SrcAE = $urandom;
      bus.SrcBE = $urandom;
      bus.op_i  = 3'($urandom_range(7, 0));
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({name, "_latency"}, 32'(cyc), 32'd33);
    check(name, bus.result_o, exp);
  endtask

  initial begin
    int dcnt;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.SrcAE   = 32'h0;
    bus.SrcBE   = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'h0, bus.stall_o}, 32'h0);
    check("reset_done", {31'h0, bus.done_o}, 32'h0);
    check("reset_result", bus.result_o, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    @(posedge clk); #1;
    @(negedge clk);
    check("mul_done_fall", {31'h0, bus.done_o}, 32'h0);
    check("mul_stall_after", {31'h0, bus.stall_o}, 32'h0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, "rem_m7_2");
    run_op(3'd4, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    run_op(3'd6, 32'h7, 32'hFFFF_FFFE, 32'h0000_0001, "rem_7_m2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, "remu_by0");
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem_neg_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

    // Flush at cycle 10 of a DIV
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'd4; bus.SrcAE = 32'd1000; bus.SrcBE = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_stall", {31'h0, bus.stall_o}, 32'h0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) dcnt++;
    end
    check("flush_no_done", 32'(dcnt), 32'h0);

    // start and flush together in IDLE
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 3'd0;
    @(negedge clk);
    check("startflush_stall", {31'h0, bus.stall_o}, 32'h0);
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    check("startflush_idle", {31'h0, bus.stall_o}, 32'h0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) dcnt++;
    end
    check("startflush_no_done", 32'(dcnt), 32'h0);

    // Asynchronous reset mid-BUSY
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 3'd0; bus.SrcAE = 32'h1234; bus.SrcBE = 32'h5678;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_stall", {31'h0, bus.stall_o}, 32'h0);
    check("arst_done", {31'h0, bus.done_o}, 32'h0);
    check("arst_result", bus.result_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_rst");

    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the forwarding muxes. It consumes the forwarded operands (SrcAE, SrcBE) and holds the pipeline with a stall while it iterates. It returns a one-cycle-valid result to the EX/MEM path. Every operation has a fixed latency, independent of operand values.

## Interface
- SIZE, 32, operand/result width; also the iteration count
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: one clock, asynchronous, active-low
- start_i  in  1  M-extension instruction present in EX
- flush_i  in  1  EX flush from hazard unit; aborts any operation
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  in  SIZE  forwarded operand A (rs1)
- SrcBE  in  SIZE  forwarded operand B (rs2)
- stall_o  out  1  holds IF/ID/EX while the operation is in flight
- done_o  out  1  result valid this cycle
- result_o  out  SIZE  result; 0 whenever done_o=0

## Operation
- FSM states:
  - IDLE, BUSY, DONE.
  - Reset state is IDLE; counter=0; all internal registers 0.
- IDLE:
  - If start_i=1 and flush_i=0, capture op_i, |SrcAE|, |SrcBE| and the sign-fix flags, then go to BUSY with counter=0.
  - Operand signedness comes from op_i: MULH signs both operands; MULHSU signs A only; DIV/REM sign both; the rest are unsigned.
- BUSY:
  - One iteration per cycle; counter increments; after iteration SIZE-1, go to DONE.
  - Multiply: shift-add into a 2·SIZE accumulator.
  - Divide: restoring, one quotient bit per cycle, SIZE-bit remainder with a carry bit.
- DONE:
  - Apply the sign fix (two's-complement negate). Multiply product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Select the output: low half for MUL; high half for MULH/MULHSU/MULHU.
  - done_o=1; return to IDLE next cycle.
- Divide by zero:
  - Quotient = all ones; remainder = original SrcAE.
  - Same latency; the iteration runs, but the output is overridden in DONE.
- Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF):
  - Quotient = 0x80000000; remainder = 0.
- flush_i=1 in any state forces IDLE next cycle, with done_o=0 and stall_o=0 that cycle. flush_i has priority over start_i.
- start_i held high in DONE does not restart the unit. The pipeline advances in DONE, so any new M instruction arrives at the next IDLE.
- Asynchronous reset mid-operation: immediately IDLE; outputs go to 0; no result is produced.

## Timing
- stall_o = (IDLE & start_i & ~flush_i) | BUSY. Combinational from state, so the stall lands in the same cycle the instruction is in EX.
- Latency: start_i seen in IDLE at cycle 0; BUSY during cycles 1..SIZE; DONE (done_o=1, stall_o=0) at cycle SIZE+1 (cycle 33 for SIZE=32).
- result_o and done_o are registered, valid only in DONE, and stable for that whole cycle.
- Back-to-back M instructions: the second start_i is accepted at cycle SIZE+2. Throughput is one operation per SIZE+2 cycles.
- SrcAE, SrcBE and op_i are sampled only on the accept edge. Later changes, including forwarding updates, are ignored.
- Reset values: stall_o=0, done_o=0, result_o=0.

## Structure
- Shared package muldiv_pkg holds:
  - op_e, the funct3 enum of the 8 ops;
  - state_e {IDLE, BUSY, DONE};
  - the constant for the counter width, $clog2(SIZE)+1.
- No sub-module is needed. One file holds the FSM, counter, accumulator/remainder datapath and output sign-fix.
- The counter is wide enough to hold SIZE-1 without wrap.

## Test plan
- MUL 7×(−3), i.e. 0x7 and 0xFFFFFFFD:
  - stall_o high for cycles 0..32.
  - done_o high for exactly one cycle at cycle 33 with result_o=0xFFFFFFEB.
  - done_o falls and stall_o stays 0 the cycle after.
- MULH/MULHSU/MULHU with A=B=0xFFFFFFFF:
  - MULH → 0x00000000; MULHSU → 0xFFFFFFFF; MULHU → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero and overflow cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - All complete in 33 cycles.
- Abort and ignored-input cases:
  - flush_i pulsed at cycle 10 of a DIV → IDLE at cycle 11 with stall_o=0 and no done_o.
  - Asserting start_i and flush_i together in IDLE → no accept.
  - Operands changed during BUSY → result unchanged.
- rst_n dropped mid-BUSY:
  - stall_o, done_o and result_o go to 0 asynchronously.
  - After release, a new MUL 3×4 → 12 at cycle 33.
